hp_bar_array: RTL and testbench
===============================

Name: hp_bar_array

Overview:
- Parametrised successor to the single-monster health bar object: N stacked horizontal HP bars (one per monster/channel) drawn at one anchor.
- Keeps per-channel HP counters with configurable damage/heal and saturation.
- Collision pulses are applied exactly once per frame, at startOfFrame.
- Feeds the VGA object mux (drawingRequest/RGBout) and exports per-channel death flags to game control.

Parameters:
- NUM_CH, 4, number of bars/channels (1..8)
- HP_MAX, 100, full health (1..255)
- DAMAGE, 10, HP removed per hit frame
- HEAL, 5, HP restored per heal frame
- PIX_PER_HP, 1, bar pixels per HP point; bar width = HP_MAX*PIX_PER_HP
- BAR_HEIGHT, 8, bar height in pixels
- BAR_GAP, 4, vertical gap between bars
- LOW_THRESHOLD, 25, HP at or below which the low colour is used
- FLASH_FRAMES, 4, frames a bar flashes after a hit
- FULL_COLOR, 8'h1C, filled colour when HP > LOW_THRESHOLD
- LOW_COLOR, 8'hE0, filled colour when HP <= LOW_THRESHOLD
- EMPTY_COLOR, 8'h49, unfilled part of a live bar
- FLASH_COLOR, 8'hFC, filled colour while flashing

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per frame
- pixelX  in  11 signed  current VGA pixel X
- pixelY  in  11 signed  current VGA pixel Y
- topLeftX  in  11 signed  anchor X of bar 0; may be negative
- topLeftY  in  11 signed  anchor Y of bar 0; may be negative
- hit  in  NUM_CH  per-channel damage collision; level or pulse, any number of cycles
- heal  in  NUM_CH  per-channel heal collision; same semantics as hit
- drawingRequest  out  1  pixel belongs to a drawn bar
- RGBout  out  8  pixel colour; 8'hFF when not drawing
- offsetX  out  11  pixelX minus bar left edge when drawing, else 0
- offsetY  out  11  pixelY minus that bar's top edge when drawing, else 0
- hp  out  8*NUM_CH  packed HP; channel i at [8i+7:8i]
- dead  out  NUM_CH  hp==0 per channel
- allDead  out  1  all channels dead

Behaviour:
- Reset, sampled on the clk edge:
  - hp[i]=HP_MAX; pending flags cleared; flash counters 0.
  - drawingRequest=0; RGBout=8'hFF; offsetX/offsetY=0.
  - dead=0; allDead=0.
  - Reset asserted mid-frame discards pending events; an event pulse in the reset cycle is ignored.
- Event capture:
  - pendHit[i] |= hit[i] and pendHeal[i] |= heal[i] every cycle.
  - Any number of cycles within one frame counts as one event.
- Apply on the startOfFrame cycle, per channel, in this order:
  1. If hp==0: ignore heal; no revival.
  2. Otherwise hp' = sat(hp - (pendHit?DAMAGE:0) + (pendHeal?HEAL:0)), clamped to [0,HP_MAX]. Compute at 10-bit signed width so there is no wrap.
  3. If pendHit and the channel was alive: flash counter = FLASH_FRAMES. Otherwise a nonzero flash counter decrements by 1.
  4. Clear pending flags. A hit/heal arriving in the same cycle as startOfFrame is captured into the next frame, not lost.
- dead/allDead are registered from hp and update the cycle after the apply.
- Geometry, bar i:
  - Top edge Ti = topLeftY + i*(BAR_HEIGHT+BAR_GAP).
  - Spans X in [topLeftX, topLeftX+HP_MAX*PIX_PER_HP) and Y in [Ti, Ti+BAR_HEIGHT).
  - All comparisons are signed. Bars do not overlap.
- Colour, one-cycle registered latency from pixelX/pixelY:
  - dead bar: not drawn; transparent, drawingRequest=0.
  - offsetX < hp*PIX_PER_HP: FLASH_COLOR if flash counter nonzero, else LOW_COLOR if hp<=LOW_THRESHOLD, else FULL_COLOR.
  - otherwise inside the bar: EMPTY_COLOR.
  - outside all bars: drawingRequest=0, RGBout=8'hFF, offsets 0.
- HP changes only at startOfFrame, so fill width never changes mid-frame.

Test Plan:
- Reset, then pixel (topLeftX+5, topLeftY+2) with anchor (32,32) -> one cycle later drawingRequest=1, RGBout=8'h1C, offsetX=5, offsetY=2; hp[0]=100.
- hit[1] held 300 cycles within one frame, then startOfFrame -> hp[1]=90 exactly. Bar 1 drawn 8'hFC for 4 frames then 8'h1C. Pixel at offsetX=95 on bar 1 -> 8'h49.
- Channel 2 at hp=5, one hit frame -> hp[2]=0, dead[2]=1. A heal frame after that leaves hp[2]=0. Bar 2 pixels give drawingRequest=0, RGBout=8'hFF.
- Channel 0 at 100, heal frame -> stays 100. hit and heal in the same frame from 50 -> 45. hp 30 to 20 -> filled colour 8'hE0.
- hit[3] asserted in the same cycle as startOfFrame -> hp[3] unchanged that frame, decremented at the next startOfFrame.
- Reset asserted mid-frame with pendHit set -> all hp=100 and no decrement at the following startOfFrame. All channels killed -> allDead=1 one cycle after the apply.

Source files
------------

// File: rtl/hp_bar_array.sv
// N stacked HP bars drawn at one anchor: per-channel HP counters with frame-applied
// damage/heal, hit flashing and death flags, plus a registered pixel colour stage.

module hp_bar_lane #(
    parameter int HP_MAX       = 100,
    parameter int DAMAGE       = 10,
    parameter int HEAL         = 5,
    parameter int FLASH_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sof_i,
    input  logic       hit_i,
    input  logic       heal_i,
    output logic [7:0] hp_o,
    output logic       flash_o
);
    localparam logic signed [9:0] DMG_S  = 10'(DAMAGE);
    localparam logic signed [9:0] HEAL_S = 10'(HEAL);
    localparam logic signed [9:0] MAX_S  = 10'(HP_MAX);

    logic [7:0]        hp_q, hp_d, flash_q, flash_d;
    logic              pend_hit_q, pend_heal_q;
    logic signed [9:0] sum;

    always_comb begin
        sum = $signed({2'b00, hp_q}) - (pend_hit_q ? DMG_S : 10'sd0)
                                     + (pend_heal_q ? HEAL_S : 10'sd0);
        // A dead channel stays dead: no heal can bring it back.
        if (hp_q == 8'd0)        hp_d = hp_q;
        else if (sum < 10'sd0)   hp_d = 8'd0;
        else if (sum > MAX_S)    hp_d = 8'(HP_MAX);
        else                     hp_d = sum[7:0];
        if (pend_hit_q && hp_q != 8'd0) flash_d = 8'(FLASH_FRAMES);
        else if (flash_q != 8'd0)       flash_d = flash_q - 8'd1;
        else                            flash_d = flash_q;
    end

    // Events seen in the startOfFrame cycle seed the next frame's pending flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            hp_q        <= 8'(HP_MAX);
            flash_q     <= 8'd0;
            pend_hit_q  <= 1'b0;
            pend_heal_q <= 1'b0;
        end else if (sof_i) begin
            hp_q        <= hp_d;
            flash_q     <= flash_d;
            pend_hit_q  <= hit_i;
            pend_heal_q <= heal_i;
        end else begin
            pend_hit_q  <= pend_hit_q | hit_i;
            pend_heal_q <= pend_heal_q | heal_i;
        end
    end

    assign hp_o    = hp_q;
    assign flash_o = (flash_q != 8'd0);
endmodule

module hp_bar_array #(
    parameter int          NUM_CH        = 4,
    parameter int          HP_MAX        = 100,
    parameter int          DAMAGE        = 10,
    parameter int          HEAL          = 5,
    parameter int          PIX_PER_HP    = 1,
    parameter int          BAR_HEIGHT    = 8,
    parameter int          BAR_GAP       = 4,
    parameter int          LOW_THRESHOLD = 25,
    parameter int          FLASH_FRAMES  = 4,
    parameter logic [7:0]  FULL_COLOR    = 8'h1C,
    parameter logic [7:0]  LOW_COLOR     = 8'hE0,
    parameter logic [7:0]  EMPTY_COLOR   = 8'h49,
    parameter logic [7:0]  FLASH_COLOR   = 8'hFC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     startOfFrame,
    input  logic signed [10:0]       pixelX,
    input  logic signed [10:0]       pixelY,
    input  logic signed [10:0]       topLeftX,
    input  logic signed [10:0]       topLeftY,
    input  logic [NUM_CH-1:0]        hit,
    input  logic [NUM_CH-1:0]        heal,
    output logic                     drawingRequest,
    output logic [7:0]               RGBout,
    output logic [10:0]              offsetX,
    output logic [10:0]              offsetY,
    output logic [8*NUM_CH-1:0]      hp,
    output logic [NUM_CH-1:0]        dead,
    output logic                     allDead
);
    localparam int BAR_W = HP_MAX * PIX_PER_HP;
    localparam int PITCH = BAR_HEIGHT + BAR_GAP;

    logic [NUM_CH-1:0][7:0] hp_w;
    logic [NUM_CH-1:0]      flash_w, dead_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        hp_bar_lane #(
            .HP_MAX(HP_MAX), .DAMAGE(DAMAGE), .HEAL(HEAL), .FLASH_FRAMES(FLASH_FRAMES)
        ) u_lane (
            .clk(clk), .reset(reset), .sof_i(startOfFrame),
            .hit_i(hit[g]), .heal_i(heal[g]),
            .hp_o(hp_w[g]), .flash_o(flash_w[g])
        );
        assign dead_d[g] = (hp_w[g] == 8'd0);
    end

    assign hp = hp_w;

    logic        draw_q, draw_d;
    logic [7:0]  rgb_q, rgb_d;
    logic [10:0] offx_q, offx_d, offy_q, offy_d;
    int          dx, dy;

    // Signed int geometry so negative anchors and far-off bars never wrap.
    always_comb begin
        draw_d = 1'b0;
        rgb_d  = 8'hFF;
        offx_d = 11'd0;
        offy_d = 11'd0;
        dy     = 0;
        dx     = int'(pixelX) - int'(topLeftX);
        for (int i = 0; i < NUM_CH; i++) begin
            dy = int'(pixelY) - int'(topLeftY) - i * PITCH;
            if (hp_w[i] != 8'd0 && dx >= 0 && dx < BAR_W && dy >= 0 && dy < BAR_HEIGHT) begin
                draw_d = 1'b1;
                offx_d = 11'(dx);
                offy_d = 11'(dy);
                if (dx < int'(hp_w[i]) * PIX_PER_HP)
                    rgb_d = flash_w[i] ? FLASH_COLOR :
                            (int'(hp_w[i]) <= LOW_THRESHOLD) ? LOW_COLOR : FULL_COLOR;
                else
                    rgb_d = EMPTY_COLOR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            draw_q    <= 1'b0;
            rgb_q     <= 8'hFF;
            offx_q    <= 11'd0;
            offy_q    <= 11'd0;
            dead      <= '0;
            allDead   <= 1'b0;
        end else begin
            draw_q    <= draw_d;
            rgb_q     <= rgb_d;
            offx_q    <= offx_d;
            offy_q    <= offy_d;
            dead      <= dead_d;
            allDead   <= &dead_d;
        end
    end

    assign drawingRequest = draw_q;
    assign RGBout         = rgb_q;
    assign offsetX        = offx_q;
    assign offsetY        = offy_q;
endmodule

// File: tb/tb_hp_bar_array.sv
// Randomized + directed bench for hp_bar_array against a frame-level reference model.

module tb_hp_bar_array;
    logic clk = 1'b0;
    logic reset, startOfFrame;
    logic signed [10:0] pixelX, pixelY, topLeftX, topLeftY;
    logic [3:0]  hit, heal;
    logic        drawingRequest;
    logic [7:0]  RGBout;
    logic [10:0] offsetX, offsetY;
    logic [31:0] hp;
    logic [3:0]  dead;
    logic        allDead;

    hp_bar_array dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY), .topLeftX(topLeftX), .topLeftY(topLeftY),
        .hit(hit), .heal(heal), .drawingRequest(drawingRequest), .RGBout(RGBout),
        .offsetX(offsetX), .offsetY(offsetY), .hp(hp), .dead(dead), .allDead(allDead)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int tlx = 32, tly = 32, px_g = 0, py_g = 0;
    int hp_m[4], fl_m[4];
    bit ph_m[4], pl_m[4], dead_m[4], alld_m;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic rpix();
        px_g = tlx + int'($urandom_range(0, 120)) - 10;
        py_g = tly + int'($urandom_range(0, 60)) - 6;
    endtask

    // Expected pixel outputs from the current model state, straight from the bar rules.
    task automatic exp_pix(input int px, input int py, output bit d, output logic [7:0] c,
                           output int ox, output int oy);
        d = 0; c = 8'hFF; ox = 0; oy = 0;
        for (int i = 0; i < 4; i++) begin
            int ty = tly + i * 12;
            if (hp_m[i] > 0 && px >= tlx && px < tlx + 100 && py >= ty && py < ty + 8) begin
                d = 1; ox = px - tlx; oy = py - ty;
                if (ox < hp_m[i]) c = (fl_m[i] > 0) ? 8'hFC : (hp_m[i] <= 25) ? 8'hE0 : 8'h1C;
                else              c = 8'h49;
            end
        end
    endtask

    task automatic cyc(bit r, logic [3:0] h, logic [3:0] l, bit s);
        bit e_d; logic [7:0] e_c; int e_ox, e_oy, v;
        reset = r; hit = h; heal = l; startOfFrame = s;
        pixelX = px_g[10:0]; pixelY = py_g[10:0];
        topLeftX = tlx[10:0]; topLeftY = tly[10:0];
        exp_pix(px_g, py_g, e_d, e_c, e_ox, e_oy);
        if (r) begin e_d = 0; e_c = 8'hFF; e_ox = 0; e_oy = 0; end
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                hp_m[i] = 100; fl_m[i] = 0; ph_m[i] = 0; pl_m[i] = 0; dead_m[i] = 0;
            end
            alld_m = 0;
        end else begin
            alld_m = 1;
            for (int i = 0; i < 4; i++) begin
                dead_m[i] = (hp_m[i] == 0);
                alld_m &= dead_m[i];
                if (s) begin
                    if (ph_m[i] && hp_m[i] > 0) fl_m[i] = 4;
                    else if (fl_m[i] > 0)       fl_m[i]--;
                    if (hp_m[i] > 0) begin
                        v = hp_m[i] - (ph_m[i] ? 10 : 0) + (pl_m[i] ? 5 : 0);
                        hp_m[i] = (v < 0) ? 0 : (v > 100) ? 100 : v;
                    end
                    ph_m[i] = h[i]; pl_m[i] = l[i];
                end else begin
                    ph_m[i] |= h[i]; pl_m[i] |= l[i];
                end
            end
        end
        #1;
        chk("draw", 32'(drawingRequest), 32'(e_d));
        chk("rgb", 32'(RGBout), 32'(e_c));
        chk("offx", 32'(offsetX), e_ox);
        chk("offy", 32'(offsetY), e_oy);
        for (int i = 0; i < 4; i++) chk("hp", 32'(hp[8*i +: 8]), hp_m[i]);
        chk("dead", 32'(dead), 32'({dead_m[3], dead_m[2], dead_m[1], dead_m[0]}));
        chk("alldead", 32'(allDead), 32'(alld_m));
    endtask

    task automatic run(int n, logic [3:0] h, logic [3:0] l);
        repeat (n) begin rpix(); cyc(0, h, l, 0); end
    endtask

    task automatic frame(logic [3:0] h, logic [3:0] l);
        run(3, h, l); rpix(); cyc(0, 4'h0, 4'h0, 1);
    endtask

    task automatic at(int x, int y);
        px_g = tlx + x; py_g = tly + y; cyc(0, 4'h0, 4'h0, 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            hp_m[i] = 100; fl_m[i] = 0; ph_m[i] = 0; pl_m[i] = 0; dead_m[i] = 0;
        end
        alld_m = 0;
        cyc(1, 4'h0, 4'h0, 0); cyc(1, 4'h0, 4'h0, 0);
        at(5, 2);
        chk("t1_draw", 32'(drawingRequest), 1); chk("t1_rgb", 32'(RGBout), 32'h1C);
        chk("t1_offx", 32'(offsetX), 5); chk("t1_offy", 32'(offsetY), 2);
        chk("t1_hp0", 32'(hp[7:0]), 100);

        run(300, 4'b0010, 4'h0); rpix(); cyc(0, 4'h0, 4'h0, 1);
        chk("hold_hp1", 32'(hp[15:8]), 90);
        at(10, 15); chk("flash_rgb", 32'(RGBout), 32'hFC);
        repeat (3) frame(4'h0, 4'h0);
        at(10, 15); chk("flash_last", 32'(RGBout), 32'hFC);
        frame(4'h0, 4'h0);
        at(10, 15); chk("flash_done", 32'(RGBout), 32'h1C);
        at(95, 15); chk("empty_rgb", 32'(RGBout), 32'h49);

        repeat (19) frame(4'b0100, 4'b0100);
        chk("ch2_5", 32'(hp[23:16]), 5);
        frame(4'b0100, 4'h0); chk("ch2_0", 32'(hp[23:16]), 0);
        at(3, 26); chk("ch2_dead", 32'(dead[2]), 1);
        chk("dead_draw", 32'(drawingRequest), 0); chk("dead_rgb", 32'(RGBout), 32'hFF);
        frame(4'h0, 4'b0100); chk("no_revive", 32'(hp[23:16]), 0);

        frame(4'h0, 4'b0001); chk("heal_sat", 32'(hp[7:0]), 100);
        repeat (5) frame(4'b0001, 4'h0);
        frame(4'b0001, 4'b0001); chk("hit_heal", 32'(hp[7:0]), 45);
        repeat (3) frame(4'b0001, 4'b0001);
        frame(4'b0001, 4'h0); chk("hp0_20", 32'(hp[7:0]), 20);
        repeat (4) frame(4'h0, 4'h0);
        at(3, 3); chk("low_rgb", 32'(RGBout), 32'hE0);

        rpix(); cyc(0, 4'b1000, 4'h0, 1); chk("sof_hit_hold", 32'(hp[31:24]), 100);
        frame(4'h0, 4'h0); chk("sof_hit_next", 32'(hp[31:24]), 90);

        run(2, 4'hF, 4'h0); rpix(); cyc(1, 4'hF, 4'h0, 0);
        frame(4'h0, 4'h0);
        chk("rst_mid", 32'(hp), 32'h64646464);

        repeat (10) frame(4'hF, 4'h0);
        chk("alld_lag", 32'(allDead), 0);
        run(1, 4'h0, 4'h0); chk("alld", 32'(allDead), 1);
        rpix(); cyc(1, 4'h0, 4'h0, 0);

        for (int f = 0; f < 300; f++) begin
            int len;
            if ($urandom_range(0, 9) == 0) begin
                tlx = int'($urandom_range(0, 450)) - 150;
                tly = int'($urandom_range(0, 450)) - 150;
            end
            len = int'($urandom_range(1, 12));
            for (int c = 0; c < len; c++) begin
                rpix();
                cyc(($urandom_range(0, 299) == 0), 4'($urandom & $urandom & $urandom),
                    4'($urandom & $urandom), (c == len - 1));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
